// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin mux8 arbiter:
//   N_REQ / SEL_W  - requester count and select width
//   state_t        - two-state FSM encoding (ST_IDLE, ST_GRANT)
//   rr_pick()      - round-robin winner search starting just after `last`
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef logic state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

    // Returns the first requester with req set, scanning last+1, last+2, ...
    // modulo N_REQ. The previous owner is visited last, which is what gives
    // every other requester priority over it. With no request the result is
    // `last`; callers only use it when |req is true.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        idx     = last;
        for (int k = 0; k < N_REQ; k++) begin
            idx = idx + SEL_W'(1);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter_if
// Request/data/handshake bundle between the requesters and the arbiter.
//   req, d, out_ready           - driven by requesters / downstream (master)
//   grant, sel, y, out_valid,
//   busy                        - driven by the arbiter (slave)
// ---------------------------------------------------------------------------
interface mux8_rr_arbiter_if #(
    parameter int DW = 1
);
    import mux_arb_pkg::*;

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] d;
    logic                out_ready;
    logic [N_REQ-1:0]    grant;
    logic [SEL_W-1:0]    sel;
    logic [DW-1:0]       y;
    logic                out_valid;
    logic                busy;

    modport master (
        output req, d, out_ready,
        input  grant, sel, y, out_valid, busy
    );

    modport slave (
        input  req, d, out_ready,
        output grant, sel, y, out_valid, busy
    );

endinterface

// File: rtl/mux8_w.sv
// ---------------------------------------------------------------------------
// mux8_w
// Width-parametric 8:1 multiplexer: y = d[sel*DW +: DW].
//   d   - eight DW-bit inputs packed, input i at bits [i*DW +: DW]
//   sel - 3-bit select
//   y   - selected DW-bit input (purely combinational)
// ---------------------------------------------------------------------------
module mux8_w
    import mux_arb_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic [N_REQ*DW-1:0] d,
    input  logic [SEL_W-1:0]    sel,
    output logic [DW-1:0]       y
);

    always_comb begin
        y = d[int'(sel)*DW +: DW];
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing one 8:1 mux output between eight requesters.
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - slave side of mux8_rr_arbiter_if:
//              req/d/out_ready in; grant/sel/y/out_valid/busy out
// A grant lasts until the owner drops its request or MAX_HOLD transfers
// (out_valid & out_ready) have completed; each release costs one IDLE cycle.
// ---------------------------------------------------------------------------
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mux8_rr_arbiter_if.slave      bus
);

    localparam logic [3:0] CNT_LAST = 4'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             owner_req;
    logic             xfer;
    logic             release_now;
    logic             out_valid;
    logic             busy;
    logic [SEL_W-1:0] winner;

    assign owner_req   = bus.req[sel_q];
    assign winner      = rr_pick(bus.req, last_q);
    assign xfer        = out_valid & bus.out_ready;
    // A dropped request is a release on its own; out_valid is already low so
    // it can never also count as a transfer.
    assign release_now = (state_q == ST_GRANT) &&
                         (!owner_req || (xfer && (cnt_q == CNT_LAST)));

    // State register (all arbiter registers share the async reset)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|bus.req)   state_d = ST_GRANT;
            ST_GRANT: if (release_now) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of select, grant, previous owner and transfer counter.
    // sel keeps its value across a release so y keeps showing the last owner.
    always_comb begin
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (|bus.req) begin
                sel_d   = winner;
                grant_d = N_REQ'(1) << winner;
                cnt_d   = '0;
            end
        end else if (release_now) begin
            grant_d = '0;
            last_d  = sel_q;
            cnt_d   = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q == ST_GRANT);
        out_valid = busy & owner_req;
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;

    mux8_w #(
        .DW (DW)
    ) u_mux (
        .d   (bus.d),
        .sel (sel_q),
        .y   (bus.y)
    );

endmodule
